// File: rtl/n25q_pkg.sv
// Shared types and constants for the N25Q SPI flash data path.
package n25q_pkg;

  // Byte engine FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StTail,
    StFin
  } spi_state_e;

  // SPI mode 3: sclk idles high, data launched on falling and captured on rising edges.
  localparam logic SPI_MODE3_CPOL = 1'b1;
  localparam logic SPI_MODE3_CPHA = 1'b1;

  localparam int unsigned N25Q_DATA_WIDTH        = 8;
  localparam int unsigned N25Q_CLK_DIVIDER_WIDTH = 8;
  localparam int unsigned N25Q_DEFAULT_DIVIDER   = 0;

  // Terminal selectors of the N25Q terminal logic feeding this engine.
  localparam logic [3:0] TERM_N25Q_CTRL = 4'h0;
  localparam logic [3:0] TERM_N25Q_DATA = 4'h1;

endpackage

// File: rtl/n25q_spi_clkgen.sv
// Half-period timer for the SPI byte engine. Counts H ifclk cycles per half and flags, on
// the last cycle of a half, whether the next half is a falling (sclk low) or rising one.
module n25q_spi_clkgen #(
  parameter int unsigned CntWidth = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                load_level_i,
  input  logic                run_i,
  input  logic [CntWidth-1:0] half_i,
  output logic                fall_o,
  output logic                rise_o
);

  logic [CntWidth-1:0] cnt_q;
  logic                level_q;
  logic                half_end;

  // Counter runs 1..H; level_q is the sclk level of the half currently being timed.
  assign half_end = (cnt_q == half_i);
  assign fall_o   = run_i & half_end & level_q;
  assign rise_o   = run_i & half_end & ~level_q;

  // Restart on load, otherwise advance while the engine is timing halves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= CntWidth'(1);
      level_q <= 1'b1;
    end else if (load_i) begin
      cnt_q   <= CntWidth'(1);
      level_q <= load_level_i;
    end else if (run_i) begin
      if (half_end) begin
        cnt_q   <= CntWidth'(1);
        level_q <= ~level_q;
      end else begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/n25q_spi_byte_engine.sv
// Byte-serial SPI mode-3 shifter. Chip select stays low between bytes until an explicit
// release, so multi-byte commands live in one csb-low window.
module n25q_spi_byte_engine
  import n25q_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = N25Q_DATA_WIDTH,
  parameter int unsigned CLK_DIVIDER_WIDTH = N25Q_CLK_DIVIDER_WIDTH,
  parameter int unsigned SAMPLE_PHASE      = 0
) (
  input  logic                         ifclk,
  input  logic                         reset,
  input  logic [CLK_DIVIDER_WIDTH-1:0] clk_divider,
  input  logic                         go,
  input  logic [DATA_WIDTH-1:0]        datai,
  input  logic                         cs_release,
  output logic [DATA_WIDTH-1:0]        datao,
  output logic                         busy,
  output logic                         done,
  output logic                         csb,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso
);

  localparam int unsigned HW  = CLK_DIVIDER_WIDTH + 1;
  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

  spi_state_e            state_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] datao_q;
  logic [HW-1:0]         half_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic                  csb_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  busy_q;
  logic                  done_q;

  logic start;
  logic run;
  logic fall;
  logic rise;
  logic last_bit;

  assign start    = (state_q == StIdle) && go;
  assign run      = (state_q == StSetup) || (state_q == StShift) || (state_q == StTail);
  assign last_bit = (bit_cnt_q == BCW'(DATA_WIDTH));

  // SETUP is timed as a high half so its end is a fall strobe; from csb low the first
  // falling half starts on the go edge itself.
  n25q_spi_clkgen #(
    .CntWidth (HW)
  ) u_clkgen (
    .clk_i        (ifclk),
    .rst_i        (reset),
    .load_i       (start),
    .load_level_i (csb_q),
    .run_i        (run),
    .half_i       (half_q),
    .fall_o       (fall),
    .rise_o       (rise)
  );

  // Transfer sequencer with registered pin and handshake outputs.
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      datao_q   <= '0;
      half_q    <= HW'(1);
      bit_cnt_q <= '0;
      csb_q     <= 1'b1;
      sclk_q    <= SPI_MODE3_CPOL;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            tx_q      <= datai;
            half_q    <= {1'b0, clk_divider} + HW'(1);
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (csb_q) begin
              state_q <= StSetup;
              csb_q   <= 1'b0;
            end else begin
              state_q <= StShift;
              sclk_q  <= 1'b0;
              mosi_q  <= datai[DATA_WIDTH-1];
            end
          end else if (cs_release) begin
            csb_q  <= 1'b1;
            mosi_q <= 1'b0;
          end
        end
        StSetup: begin
          if (fall) begin
            state_q <= StShift;
            sclk_q  <= 1'b0;
            mosi_q  <= tx_q[DATA_WIDTH-1];
          end
        end
        StShift: begin
          if (rise) begin
            sclk_q    <= 1'b1;
            tx_q      <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
            if (SAMPLE_PHASE == 0) begin
              rx_q <= {rx_q[DATA_WIDTH-2:0], miso};
            end
          end else if (fall) begin
            // Late sampling takes the bit from the preceding rising half here.
            if (SAMPLE_PHASE != 0) begin
              rx_q <= {rx_q[DATA_WIDTH-2:0], miso};
            end
            if (last_bit) begin
              if (SAMPLE_PHASE != 0) begin
                state_q <= StTail;
              end else begin
                state_q <= StFin;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                datao_q <= rx_q;
              end
            end else begin
              sclk_q <= 1'b0;
              mosi_q <= tx_q[DATA_WIDTH-1];
            end
          end
        end
        StTail: begin
          if (fall || rise) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            datao_q <= rx_q;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign datao = datao_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign csb   = csb_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_n25q_spi_byte_engine.sv
// Directed bench for the N25Q SPI byte engine: one instance per sample phase, sharing
// the request inputs, each with its own flash-side miso model.
module tb_n25q_spi_byte_engine;

  logic       ifclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] clk_divider = 8'd0;
  logic       go = 1'b0;
  logic [7:0] datai = 8'd0;
  logic       cs_release = 1'b0;

  logic [7:0] datao0, datao1;
  logic       busy0, busy1, done0, done1, csb0, csb1, sclk0, sclk1, mosi0, mosi1;
  logic       miso0 = 1'b0;
  logic       miso1 = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  // Flash model bytes and their shift registers.
  logic [7:0] pat0 = 8'h00, pat1 = 8'h00, sh0 = 8'h00, sh1 = 8'h00;

  // Per-transfer observations.
  int         r_cyc, r_lows, r_lowcyc;
  logic [7:0] r_mseq;
  bit         r_csb_hi, r_busy_bad, r_csb_c1;

  n25q_spi_byte_engine #(
    .DATA_WIDTH        (8),
    .CLK_DIVIDER_WIDTH (8),
    .SAMPLE_PHASE      (0)
  ) u_dut0 (
    .ifclk       (ifclk),
    .reset       (reset),
    .clk_divider (clk_divider),
    .go          (go),
    .datai       (datai),
    .cs_release  (cs_release),
    .datao       (datao0),
    .busy        (busy0),
    .done        (done0),
    .csb         (csb0),
    .sclk        (sclk0),
    .mosi        (mosi0),
    .miso        (miso0)
  );

  n25q_spi_byte_engine #(
    .DATA_WIDTH        (8),
    .CLK_DIVIDER_WIDTH (8),
    .SAMPLE_PHASE      (1)
  ) u_dut1 (
    .ifclk       (ifclk),
    .reset       (reset),
    .clk_divider (clk_divider),
    .go          (go),
    .datai       (datai),
    .cs_release  (cs_release),
    .datao       (datao1),
    .busy        (busy1),
    .done        (done1),
    .csb         (csb1),
    .sclk        (sclk1),
    .mosi        (mosi1),
    .miso        (miso1)
  );

  initial forever #5 ifclk = ~ifclk;

  // Flash for instance 0 drives each bit just after sclk falls.
  initial forever begin
    @(negedge sclk0);
    #1;
    miso0 = sh0[7];
    sh0   = {sh0[6:0], 1'b0};
  end

  // Flash for instance 1 arrives one half-period late: bit appears after sclk rises.
  initial forever begin
    @(posedge sclk1);
    #1;
    miso1 = sh1[7];
    sh1   = {sh1[6:0], 1'b0};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge ifclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue go with byte d, watch instance sel until done; optional mid-transfer injection
  // of go, cs_release and a new divider at cycle inj. r_cyc=9999 on timeout.
  task automatic xfer(input logic [7:0] d, input bit sel, input int inj, input int maxc);
    logic prev, s, cs, dn, bz, mo;
    sh0        = pat0;
    sh1        = pat1;
    datai      = d;
    go         = 1'b1;
    prev       = 1'b1;
    r_lows     = 0;
    r_lowcyc   = 0;
    r_mseq     = 8'h00;
    r_csb_hi   = 1'b0;
    r_busy_bad = 1'b0;
    r_csb_c1   = 1'b1;
    tick;
    go         = 1'b0;
    cs_release = 1'b0;
    r_cyc      = 1;
    forever begin
      s  = sel ? sclk1 : sclk0;
      cs = sel ? csb1 : csb0;
      dn = sel ? done1 : done0;
      bz = sel ? busy1 : busy0;
      mo = sel ? mosi1 : mosi0;
      if (r_cyc == 1) r_csb_c1 = cs;
      if (prev && !s) begin
        r_lows++;
        r_mseq = {r_mseq[6:0], mo};
      end
      if (!s) r_lowcyc++;
      prev = s;
      if (cs) r_csb_hi = 1'b1;
      if (dn) begin
        if (bz) r_busy_bad = 1'b1;
        break;
      end
      if (!bz) r_busy_bad = 1'b1;
      if (r_cyc >= maxc) begin
        r_cyc = 9999;
        break;
      end
      if (r_cyc == inj) begin
        go          = 1'b1;
        cs_release  = 1'b1;
        clk_divider = 8'd0;
        datai       = 8'h00;
      end else if (r_cyc == inj + 1) begin
        go         = 1'b0;
        cs_release = 1'b0;
      end
      tick;
      r_cyc++;
    end
  endtask

  initial begin
    // Reset values
    tick;
    tick;
    chk("rst_csb", csb0, 1);
    chk("rst_sclk", sclk0, 1);
    chk("rst_mosi", mosi0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_datao", datao0, 8'h00);
    reset = 1'b0;
    tick;

    // Single byte at full speed
    clk_divider = 8'd0;
    pat0 = 8'h3C;
    xfer(8'hA5, 1'b0, 0, 40);
    chk("t1_csb_c1", r_csb_c1, 0);
    chk("t1_done_cyc", r_cyc, 18);
    chk("t1_lows", r_lows, 8);
    chk("t1_lowcyc", r_lowcyc, 8);
    chk("t1_mosi_seq", r_mseq, 8'hA5);
    chk("t1_datao", datao0, 8'h3C);
    chk("t1_csb_hi", r_csb_hi, 0);
    chk("t1_busy", r_busy_bad, 0);
    chk("t1_csb_done", csb0, 0);

    // Idle with csb low: mosi holds last bit; release raises csb and clears mosi
    tick;
    chk("rel_mosi_hold", mosi0, 1);
    chk("rel_csb_before", csb0, 0);
    cs_release = 1'b1;
    tick;
    cs_release = 1'b0;
    chk("rel_csb", csb0, 1);
    chk("rel_sclk", sclk0, 1);
    chk("rel_mosi", mosi0, 0);

    // Back-to-back bytes
    pat0 = 8'hC2;
    xfer(8'h9F, 1'b0, 0, 40);
    chk("b2b1_done_cyc", r_cyc, 18);
    chk("b2b1_datao", datao0, 8'hC2);
    chk("b2b1_mosi_seq", r_mseq, 8'h9F);
    tick;
    chk("b2b_gap_csb", csb0, 0);
    pat0 = 8'h81;
    xfer(8'h00, 1'b0, 0, 40);
    chk("b2b2_done_cyc", r_cyc, 17);
    chk("b2b2_csb_hi", r_csb_hi, 0);
    chk("b2b2_datao", datao0, 8'h81);
    chk("b2b2_mosi_seq", r_mseq, 8'h00);
    chk("b2b2_lows", r_lows, 8);
    tick;
    cs_release = 1'b1;
    tick;
    cs_release = 1'b0;
    chk("rel2_csb", csb0, 1);

    // Ignored requests mid-SHIFT, H=2 from csb high: done at 1+2+32
    clk_divider = 8'd1;
    pat0 = 8'h69;
    xfer(8'h96, 1'b0, 10, 50);
    chk("ign_done_cyc", r_cyc, 35);
    chk("ign_csb_hi", r_csb_hi, 0);
    chk("ign_mosi_seq", r_mseq, 8'h96);
    chk("ign_lows", r_lows, 8);
    chk("ign_lowcyc", r_lowcyc, 16);
    chk("ign_datao", datao0, 8'h69);
    chk("ign_busy", r_busy_bad, 0);

    // cs_release together with go in IDLE: go wins, divider now 0, csb already low
    tick;
    cs_release = 1'b1;
    pat0 = 8'h5A;
    xfer(8'hC5, 1'b0, 0, 40);
    chk("gorel_done_cyc", r_cyc, 17);
    chk("gorel_csb_c1", r_csb_c1, 0);
    chk("gorel_csb_hi", r_csb_hi, 0);
    chk("gorel_datao", datao0, 8'h5A);
    chk("gorel_mosi_seq", r_mseq, 8'hC5);

    // Reset at cycle 9 of a transfer started from csb high
    tick;
    cs_release = 1'b1;
    tick;
    cs_release = 1'b0;
    datai = 8'hF0;
    go = 1'b1;
    tick;
    go = 1'b0;
    repeat (8) tick;
    chk("mid_busy", busy0, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_csb", csb0, 1);
    chk("mid_rst_sclk", sclk0, 1);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_datao", datao0, 8'h00);
    tick;
    reset = 1'b0;
    tick;
    chk("mid_post_done", done0, 0);
    pat0 = 8'hE7;
    xfer(8'h18, 1'b0, 0, 40);
    chk("mid_new_done_cyc", r_cyc, 18);
    chk("mid_new_datao", datao0, 8'hE7);
    chk("mid_new_mosi_seq", r_mseq, 8'h18);

    // Divided clock with late sample on instance 1: done at 1+4+64+4
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    clk_divider = 8'd3;
    pat1 = 8'hC3;
    xfer(8'hFF, 1'b1, 0, 100);
    chk("sp1_done_cyc", r_cyc, 73);
    chk("sp1_lows", r_lows, 8);
    chk("sp1_lowcyc", r_lowcyc, 32);
    chk("sp1_mosi_seq", r_mseq, 8'hFF);
    chk("sp1_datao", datao1, 8'hC3);
    chk("sp1_csb_hi", r_csb_hi, 0);
    chk("sp1_busy", r_busy_bad, 0);
    chk("sp1_sclk_fin", sclk1, 1);
    tick;
    chk("sp1_done_clr", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
